// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared encodings and time arithmetic for the countdown alarm sequencer
package alarm_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EDIT_HH = 3'd1,
        S_EDIT_MM = 3'd2,
        S_EDIT_SS = 3'd3,
        S_RUN     = 3'd4,
        S_PAUSED  = 3'd5,
        S_RINGING = 3'd6
    } state_t;

    localparam int SEC_PER_MIN = 60;
    localparam int SEC_PER_HR  = 3600;
    localparam int MAX_MM_SS   = 59;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_HH   = 2'd1;
    localparam logic [1:0] SEL_MM   = 2'd2;
    localparam logic [1:0] SEL_SS   = 2'd3;

    function automatic logic [16:0] to_seconds(input logic [5:0] hh,
                                               input logic [5:0] mm,
                                               input logic [5:0] ss);
        return 17'(hh) * 17'(SEC_PER_HR) + 17'(mm) * 17'(SEC_PER_MIN) + 17'(ss);
    endfunction

endpackage

// File: rtl/alarm_ctrl_wrap_field.sv
// rtl/alarm_ctrl_wrap_field.sv - 6-bit up/down counter wrapping between 0 and MAX, with load
module wrap_field #(
    parameter int MAX = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    input  logic       load,
    input  logic [5:0] load_val,
    output logic [5:0] value
);

    localparam logic [5:0] MAX_V = 6'(MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= 6'd0;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            value <= (value == MAX_V) ? 6'd0 : value + 6'd1;
        end else if (dec) begin
            value <= (value == 6'd0) ? MAX_V : value - 6'd1;
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - button-driven HH:MM:SS setter, countdown sequencer and ring timeout
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int RING_SEC = 30,
    parameter int MAX_HH   = 23
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        btn_start,
    input  logic [16:0] remaining,
    output logic [16:0] start_time,
    output logic        timer_clr_n,
    output logic        timer_run,
    output logic [1:0]  edit_sel,
    output logic        ringing,
    output logic [2:0]  state_o
);

    localparam int PCW = $clog2(CLK_HZ + 1);
    localparam int RCW = $clog2(RING_SEC + 1);
    localparam logic [PCW-1:0] PRE_LAST  = PCW'(CLK_HZ - 1);
    localparam logic [RCW-1:0] RING_LAST = RCW'(RING_SEC - 1);

    state_t         state, next_state;
    logic [3:0]     btn_q;
    logic           armed;
    logic [3:0]     ev;
    logic           take_start, take_mode, take_inc, take_dec;
    logic [5:0]     hh, mm, ss;
    logic [1:0]     guard;
    logic [PCW-1:0] prescaler;
    logic [RCW-1:0] ring_cnt;
    logic           pre_wrap;
    logic           enter_run, clr_exit;

    // armed masks the first cycle after reset so a held button is not seen as an edge
    assign ev = armed ? ({btn_start, btn_mode, btn_inc, btn_dec} & ~btn_q) : 4'b0000;

    assign take_start = ev[3];
    assign take_mode  = ev[2] & ~ev[3];
    assign take_inc   = ev[1] & ~ev[3] & ~ev[2];
    assign take_dec   = ev[0] & ~ev[3] & ~ev[2] & ~ev[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_q <= 4'b0000;
            armed <= 1'b0;
        end else begin
            btn_q <= {btn_start, btn_mode, btn_inc, btn_dec};
            armed <= 1'b1;
        end
    end

    wrap_field #(.MAX(MAX_HH)) u_hh (
        .clk(clk), .reset(reset),
        .inc(take_inc && state == S_EDIT_HH), .dec(take_dec && state == S_EDIT_HH),
        .load(1'b0), .load_val(6'd0), .value(hh)
    );

    wrap_field #(.MAX(MAX_MM_SS)) u_mm (
        .clk(clk), .reset(reset),
        .inc(take_inc && state == S_EDIT_MM), .dec(take_dec && state == S_EDIT_MM),
        .load(1'b0), .load_val(6'd0), .value(mm)
    );

    wrap_field #(.MAX(MAX_MM_SS)) u_ss (
        .clk(clk), .reset(reset),
        .inc(take_inc && state == S_EDIT_SS), .dec(take_dec && state == S_EDIT_SS),
        .load(1'b0), .load_val(6'd0), .value(ss)
    );

    assign pre_wrap = (prescaler == PRE_LAST);

    always_comb begin
        next_state = state;
        enter_run  = 1'b0;
        clr_exit   = 1'b0;
        case (state)
            S_IDLE, S_EDIT_HH, S_EDIT_MM, S_EDIT_SS: begin
                if (take_start) begin
                    if (start_time != 17'd0) begin
                        next_state = S_RUN;
                        enter_run  = 1'b1;
                    end
                end else if (take_mode) begin
                    case (state)
                        S_IDLE:    next_state = S_EDIT_HH;
                        S_EDIT_HH: next_state = S_EDIT_MM;
                        S_EDIT_MM: next_state = S_EDIT_SS;
                        default:   next_state = S_IDLE;
                    endcase
                end
            end
            S_RUN: begin
                if (take_start) begin
                    next_state = S_PAUSED;
                end else if (remaining == 17'd0 && guard == 2'd0) begin
                    next_state = S_RINGING;
                end
            end
            S_PAUSED: begin
                if (take_start) begin
                    next_state = S_RUN;
                end else if (take_mode) begin
                    next_state = S_IDLE;
                    clr_exit   = 1'b1;
                end
            end
            S_RINGING: begin
                if (take_start || (pre_wrap && ring_cnt == RING_LAST)) begin
                    next_state = S_IDLE;
                    clr_exit   = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            start_time  <= 17'd0;
            timer_clr_n <= 1'b1;
            timer_run   <= 1'b0;
            guard       <= 2'd0;
        end else begin
            state       <= next_state;
            start_time  <= to_seconds(hh, mm, ss);
            timer_clr_n <= ~(enter_run | clr_exit);
            timer_run   <= (next_state == S_RUN) && !enter_run;
            // timer output reads 0 right after its clear; hold off the done check meanwhile
            if (enter_run) begin
                guard <= 2'd2;
            end else if (guard != 2'd0) begin
                guard <= guard - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            ring_cnt  <= '0;
        end else if (state != S_RINGING) begin
            prescaler <= '0;
            ring_cnt  <= '0;
        end else if (pre_wrap) begin
            prescaler <= '0;
            ring_cnt  <= ring_cnt + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    always_comb begin
        edit_sel = SEL_NONE;
        case (state)
            S_EDIT_HH: edit_sel = SEL_HH;
            S_EDIT_MM: edit_sel = SEL_MM;
            S_EDIT_SS: edit_sel = SEL_SS;
            default:   edit_sel = SEL_NONE;
        endcase
    end

    assign ringing = (state == S_RINGING);
    assign state_o = state;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb/tb_alarm_ctrl.sv - directed self-checking bench for alarm_ctrl (CLK_HZ=10, RING_SEC=3)
module tb_alarm_ctrl;

    localparam logic [3:0] B_MODE  = 4'b0001;
    localparam logic [3:0] B_INC   = 4'b0010;
    localparam logic [3:0] B_DEC   = 4'b0100;
    localparam logic [3:0] B_START = 4'b1000;

    logic        clk;
    logic        reset;
    logic [3:0]  btn;
    logic [16:0] remaining;
    logic [16:0] start_time;
    logic        timer_clr_n;
    logic        timer_run;
    logic [1:0]  edit_sel;
    logic        ringing;
    logic [2:0]  state_o;

    int n_checks = 0;
    int n_fail   = 0;

    alarm_ctrl #(.CLK_HZ(10), .RING_SEC(3), .MAX_HH(23)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn[0]), .btn_inc(btn[1]), .btn_dec(btn[2]), .btn_start(btn[3]),
        .remaining(remaining), .start_time(start_time), .timer_clr_n(timer_clr_n),
        .timer_run(timer_run), .edit_sel(edit_sel), .ringing(ringing), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] b);
        btn = b;
        tick();
        btn = 4'b0000;
        tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b0;
        btn       = B_MODE;
        remaining = 17'd0;
        tick();
        tick();
        chk("rst_state", state_o, 0);
        chk("rst_start_time", start_time, 0);
        chk("rst_clr_n", timer_clr_n, 1);
        chk("rst_run", timer_run, 0);
        chk("rst_edit_sel", edit_sel, 0);
        chk("rst_ringing", ringing, 0);
        reset = 1'b1;
        tick();
        tick();
        chk("held_mode_no_event", state_o, 0);
        btn = 4'b0000;
        tick();

        // 1: field entry
        press(B_MODE);
        chk("t1_sel_hh", edit_sel, 1);
        press(B_INC);
        press(B_INC);
        press(B_MODE);
        chk("t1_sel_mm", edit_sel, 2);
        press(B_DEC);
        press(B_MODE);
        chk("t1_sel_ss", edit_sel, 3);
        for (int i = 0; i < 5; i++) press(B_INC);
        chk("t1_start_time", start_time, 10745);

        // 2: hour and second wrap
        press(B_MODE);
        chk("t2_idle", state_o, 0);
        press(B_MODE);
        for (int i = 0; i < 3; i++) press(B_DEC);
        chk("t2_hh23", start_time, 86345);
        btn = B_INC;
        tick();
        chk("t2_hh_wrap_lag", start_time, 86345);
        btn = 4'b0000;
        tick();
        chk("t2_hh_wrap", start_time, 3545);
        press(B_MODE);
        press(B_MODE);
        for (int i = 0; i < 5; i++) press(B_DEC);
        chk("t2_ss0", start_time, 3540);
        press(B_DEC);
        chk("t2_ss_wrap_dn", start_time, 3599);
        press(B_INC);
        chk("t2_ss_wrap_up", start_time, 3540);
        btn = B_INC | B_DEC;
        tick();
        btn = 4'b0000;
        tick();
        chk("t2_inc_over_dec", start_time, 3541);
        press(B_DEC);

        // 3: start with zero time is ignored
        press(B_MODE);
        press(B_MODE);
        press(B_MODE);
        press(B_INC);
        chk("t3_zero", start_time, 0);
        press(B_MODE);
        press(B_MODE);
        chk("t3_idle", state_o, 0);
        btn = B_START;
        tick();
        chk("t3_state", state_o, 0);
        chk("t3_clr_n", timer_clr_n, 1);
        btn = 4'b0000;
        tick();
        chk("t3_run", timer_run, 0);
        chk("t3_clr_n2", timer_clr_n, 1);

        // 4: start, done guard, acknowledge
        press(B_MODE);
        press(B_MODE);
        press(B_MODE);
        for (int i = 0; i < 5; i++) press(B_INC);
        chk("t4_five", start_time, 5);
        btn = B_START;
        tick();
        chk("t4_entry_state", state_o, 4);
        chk("t4_entry_clr_n", timer_clr_n, 0);
        chk("t4_entry_run", timer_run, 0);
        chk("t4_entry_sel", edit_sel, 0);
        btn = 4'b0000;
        tick();
        chk("t4_e1_clr_n", timer_clr_n, 1);
        chk("t4_e1_run", timer_run, 1);
        chk("t4_e1_ring", ringing, 0);
        tick();
        chk("t4_e2_ring", ringing, 0);
        chk("t4_e2_state", state_o, 4);
        tick();
        chk("t4_e3_ring", ringing, 1);
        chk("t4_e3_run", timer_run, 0);
        btn = B_START;
        tick();
        chk("t4_ack_state", state_o, 0);
        chk("t4_ack_clr_n", timer_clr_n, 0);
        btn = 4'b0000;
        tick();
        chk("t4_ack_clr_n2", timer_clr_n, 1);
        chk("t4_hold", start_time, 5);

        // 5: ring timeout after 3*10 cycles
        press(B_START);
        tick();
        tick();
        chk("t5_r0", ringing, 1);
        for (int i = 0; i < 29; i++) tick();
        chk("t5_r29", ringing, 1);
        chk("t5_r29_clr_n", timer_clr_n, 1);
        tick();
        chk("t5_r30_state", state_o, 0);
        chk("t5_r30_clr_n", timer_clr_n, 0);

        // 6: start+inc in RUN, abort from PAUSED, reset mid-RUN
        remaining = 17'd7;
        press(B_START);
        chk("t6_run", timer_run, 1);
        btn = B_START | B_INC;
        tick();
        chk("t6_paused", state_o, 5);
        chk("t6_paused_run", timer_run, 0);
        btn = 4'b0000;
        tick();
        chk("t6_no_field", start_time, 5);
        btn = B_MODE;
        tick();
        chk("t6_abort_state", state_o, 0);
        chk("t6_abort_clr_n", timer_clr_n, 0);
        btn = 4'b0000;
        tick();
        chk("t6_kept", start_time, 5);
        press(B_START);
        chk("t6_run2", state_o, 4);
        reset = 1'b0;
        #1;
        chk("t6_rst_state", state_o, 0);
        chk("t6_rst_start_time", start_time, 0);
        chk("t6_rst_clr_n", timer_clr_n, 1);
        chk("t6_rst_run", timer_run, 0);
        chk("t6_rst_ring", ringing, 0);
        tick();
        reset = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
